// File: rtl/decode_pkg.sv
// Shared types for the decode queue: opcode classes, format codes and the decoded entry.
package decode_pkg;

  localparam logic [2:0] CLS_BASE    = 3'd0;
  localparam logic [2:0] CLS_ALU_IMM = 3'd1;
  localparam logic [2:0] CLS_REG_EXT = 3'd3;
  localparam logic [2:0] CLS_MEM_LD  = 3'd4;
  localparam logic [2:0] CLS_MEM_ST  = 3'd5;

  localparam logic [2:0] SUB_R  = 3'd0;
  localparam logic [2:0] SUB_J0 = 3'd2;
  localparam logic [2:0] SUB_J1 = 3'd3;

  typedef enum logic [1:0] {
    FMT_R    = 2'd0,
    FMT_I    = 2'd1,
    FMT_J    = 2'd2,
    FMT_NONE = 2'd3
  } fmt_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sha;
    logic [5:0]  func;
    logic [15:0] immed;
    logic [25:0] target;
    fmt_e        format;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/insn_field_decoder.sv
// Combinational instruction field decoder; fields unused by the detected format are zero.
module insn_field_decoder
  import decode_pkg::*;
(
  input  logic [31:0] insn,
  output decoded_t    dec
);

  logic [2:0] cls_s;
  logic [2:0] sub_s;
  fmt_e       fmt_s;

  assign cls_s = insn[31:29];
  assign sub_s = insn[28:26];

  // Classify the opcode into a format
  always_comb begin
    fmt_s = FMT_NONE;
    case (cls_s)
      CLS_BASE: begin
        case (sub_s)
          SUB_R:          fmt_s = FMT_R;
          SUB_J0, SUB_J1: fmt_s = FMT_J;
          default:        fmt_s = FMT_I;
        endcase
      end
      CLS_ALU_IMM, CLS_MEM_LD, CLS_MEM_ST: fmt_s = FMT_I;
      CLS_REG_EXT:                         fmt_s = FMT_R;
      default:                             fmt_s = FMT_NONE;
    endcase
  end

  // Extract only the fields that belong to the format
  always_comb begin
    dec        = '0;
    dec.opcode = insn[31:26];
    dec.format = fmt_s;
    case (fmt_s)
      FMT_R: begin
        dec.rs   = insn[25:21];
        dec.rt   = insn[20:16];
        dec.rd   = insn[15:11];
        dec.sha  = insn[10:6];
        dec.func = insn[5:0];
      end
      FMT_I: begin
        dec.rs    = insn[25:21];
        dec.rt    = insn[20:16];
        dec.immed = insn[15:0];
      end
      FMT_J: begin
        dec.target = insn[25:0];
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Queue of pre-decoded instructions; decode happens at push, outputs come from head storage.
// Optional illegal-instruction counter enabled by macro DECODE_QUEUE_STATS_EN.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               insn_in,
  input  logic [PC_WIDTH-1:0]       pc_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic [5:0]                out_opcode,
  output logic [4:0]                out_rs,
  output logic [4:0]                out_rt,
  output logic [4:0]                out_rd,
  output logic [4:0]                out_sha,
  output logic [5:0]                out_func,
  output logic [15:0]               out_immed,
  output logic [25:0]               out_target,
  output logic [1:0]                out_format,
  output logic                      out_illegal,
`ifdef DECODE_QUEUE_STATS_EN
  output logic [15:0]               illegal_count,
`endif
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  decoded_t              mem_r    [DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  decoded_t              dec_s;
  decoded_t              head_s;
  logic                  push_s;
  logic                  pop_s;

  insn_field_decoder u_dec (
    .insn (insn_in),
    .dec  (dec_s)
  );

  // A full queue never accepts, even when the head is leaving this cycle
  assign in_ready  = (count_r < CW'(DEPTH));
  assign out_valid = (count_r != CW'(0));
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign count     = count_r;

  assign head_s      = mem_r[rd_ptr_r];
  assign out_pc      = pc_mem_r[rd_ptr_r];
  assign out_opcode  = head_s.opcode;
  assign out_rs      = head_s.rs;
  assign out_rt      = head_s.rt;
  assign out_rd      = head_s.rd;
  assign out_sha     = head_s.sha;
  assign out_func    = head_s.func;
  assign out_immed   = head_s.immed;
  assign out_target  = head_s.target;
  assign out_format  = head_s.format;
  assign out_illegal = head_s.illegal;

  // Storage, pointers and occupancy; storage is cleared on reset so the head reads zero
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i]    <= '0;
        pc_mem_r[i] <= PC_WIDTH'(0);
      end
    end else if (flush) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r]    <= dec_s;
        pc_mem_r[wr_ptr_r] <= pc_in;
        wr_ptr_r           <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef DECODE_QUEUE_STATS_EN
  logic [15:0] illegal_count_r;

  // Saturating count of accepted illegal instructions; survives flush
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_count_r <= 16'd0;
    end else if (push_s && !flush && dec_s.illegal && (illegal_count_r != 16'hFFFF)) begin
      illegal_count_r <= illegal_count_r + 16'd1;
    end else begin
      illegal_count_r <= illegal_count_r;
    end
  end

  assign illegal_count = illegal_count_r;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios plus random traffic against a queue model.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int PCW   = 32;

  logic             clock = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      insn_in;
  logic [PCW-1:0]   pc_in, out_pc;
  logic [5:0]       out_opcode, out_func;
  logic [4:0]       out_rs, out_rt, out_rd, out_sha;
  logic [15:0]      out_immed;
  logic [25:0]      out_target;
  logic [1:0]       out_format;
  logic             out_illegal;
  logic [2:0]       count;
`ifdef DECODE_QUEUE_STATS_EN
  logic [15:0]      illegal_count;
`endif

  decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .insn_in(insn_in), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_sha(out_sha), .out_func(out_func), .out_immed(out_immed),
    .out_target(out_target), .out_format(out_format), .out_illegal(out_illegal),
`ifdef DECODE_QUEUE_STATS_EN
    .illegal_count(illegal_count),
`endif
    .count(count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sha;
    logic [5:0]  fn;
    logic [15:0] im;
    logic [25:0] tg;
    logic [1:0]  fmt;
    logic        ill;
  } ref_t;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [31:0]  q_insn[$];
  logic [31:0]  q_pc[$];
  int           stat_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    int   op, cls, sub, fmt;
    r   = '0;
    op  = int'(w[31:26]);
    cls = op / 8;
    sub = op % 8;
    if (cls == 0)                          fmt = (sub == 0) ? 0 : ((sub == 2 || sub == 3) ? 2 : 1);
    else if (cls == 1 || cls == 4 || cls == 5) fmt = 1;
    else if (cls == 3)                     fmt = 0;
    else                                   fmt = 3;
    r.op  = w[31:26];
    r.fmt = fmt[1:0];
    if (fmt == 0) begin
      r.rs = w[25:21]; r.rt = w[20:16]; r.rd = w[15:11]; r.sha = w[10:6]; r.fn = w[5:0];
    end else if (fmt == 1) begin
      r.rs = w[25:21]; r.rt = w[20:16]; r.im = w[15:0];
    end else if (fmt == 2) begin
      r.tg = w[25:0];
    end else begin
      r.ill = 1'b1;
    end
    return r;
  endfunction

  task automatic check_outputs();
    ref_t e;
    check("count", 64'(count), 64'(q_insn.size()));
    check("in_ready", 64'(in_ready), 64'(q_insn.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(q_insn.size() != 0));
`ifdef DECODE_QUEUE_STATS_EN
    check("illegal_count", 64'(illegal_count), 64'(stat_cnt));
`endif
    if (q_insn.size() != 0) begin
      e = ref_decode(q_insn[0]);
      check("pc", 64'(out_pc), 64'(q_pc[0]));
      check("opcode", 64'(out_opcode), 64'(e.op));
      check("rs", 64'(out_rs), 64'(e.rs));
      check("rt", 64'(out_rt), 64'(e.rt));
      check("rd", 64'(out_rd), 64'(e.rd));
      check("sha", 64'(out_sha), 64'(e.sha));
      check("func", 64'(out_func), 64'(e.fn));
      check("immed", 64'(out_immed), 64'(e.im));
      check("target", 64'(out_target), 64'(e.tg));
      check("format", 64'(out_format), 64'(e.fmt));
      check("illegal", 64'(out_illegal), 64'(e.ill));
    end
  endtask

  // One clock: apply inputs, advance the model by the same rules, check just after the edge
  task automatic step(input logic rst, input logic v, input logic [31:0] w,
                      input logic [31:0] pc, input logic rdy, input logic fl);
    logic do_push, do_pop;
    reset = rst; in_valid = v; insn_in = w; pc_in = pc; out_ready = rdy; flush = fl;
    do_push = v && (q_insn.size() < DEPTH);
    do_pop  = rdy && (q_insn.size() != 0);
    @(posedge clock);
    if (rst) begin
      q_insn.delete(); q_pc.delete(); stat_cnt = 0;
    end else if (fl) begin
      q_insn.delete(); q_pc.delete();
    end else begin
      if (do_pop) begin
        void'(q_insn.pop_front()); void'(q_pc.pop_front());
      end
      if (do_push) begin
        q_insn.push_back(w); q_pc.push_back(pc);
        if (ref_decode(w).ill && stat_cnt < 65535) stat_cnt++;
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    insn_in = 32'd0; pc_in = 32'd0;

    step(1'b1, 1'b1, 32'h012A4020, 32'h100, 1'b1, 1'b0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_zero_fields", 64'({out_pc, out_opcode, out_rs, out_rt, out_rd}), 64'd0);
    check("rst_zero_rest", 64'({out_sha, out_func, out_immed, out_format, out_illegal}), 64'd0);
    check("rst_zero_target", 64'(out_target), 64'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // add $8,$9,$10
    step(1'b0, 1'b1, 32'h012A4020, 32'h400, 1'b0, 1'b0);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_fmt", 64'(out_format), 64'd0);
    check("add_rs", 64'(out_rs), 64'd9);
    check("add_rt", 64'(out_rt), 64'd10);
    check("add_rd", 64'(out_rd), 64'd8);
    check("add_func", 64'(out_func), 64'h20);
    check("add_immed", 64'(out_immed), 64'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    step(1'b0, 1'b1, 32'h08000010, 32'h404, 1'b0, 1'b0);
    check("j_fmt", 64'(out_format), 64'd2);
    check("j_target", 64'(out_target), 64'h10);
    check("j_regs", 64'({out_rs, out_rt, out_rd}), 64'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    step(1'b0, 1'b1, 32'h4123_4567, 32'h408, 1'b0, 1'b0);
    check("ill_flag", 64'(out_illegal), 64'd1);
    check("ill_fmt", 64'(out_format), 64'd3);
`ifdef DECODE_QUEUE_STATS_EN
    check("ill_stat", 64'(illegal_count), 64'd1);
`endif
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Fill past capacity, then drain in order
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, $urandom, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
      if (i == 3) check("full_ready", 64'(in_ready), 64'd0);
    end
    check("full_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("drained_valid", 64'(out_valid), 64'd0);

    // Wrapped pointers, then simultaneous push and pop at count 2
    step(1'b0, 1'b1, $urandom, 32'h600, 1'b0, 1'b0);
    step(1'b0, 1'b1, $urandom, 32'h604, 1'b0, 1'b0);
    step(1'b0, 1'b1, $urandom, 32'h608, 1'b1, 1'b0);
    check("pushpop_count", 64'(count), 64'd2);
    check("pushpop_head", 64'(out_pc), 64'h604);

    // Flush at count 3 with a push pending
    step(1'b0, 1'b1, $urandom, 32'h60C, 1'b0, 1'b0);
    check("pre_flush_count", 64'(count), 64'd3);
    step(1'b0, 1'b1, $urandom, 32'h610, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Push on empty with pop asserted
    step(1'b0, 1'b1, 32'h2000_0001, 32'h700, 1'b1, 1'b0);
    check("empty_pushpop_count", 64'(count), 64'd1);

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 7), $urandom, $urandom,
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 24) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
